// File: rtl/video_led_sched.sv
// Frame-synchronous LED scheduler: two requesters share an LED shadow through a
// round-robin arbiter; the shadow (with optional blink overlay) is committed on FRAME_i.
module video_led_sched #(
  parameter int C_BLINK_FRAMES = 30,
  parameter int C_LED_N        = 18
) (
  input  logic               CK_i,
  input  logic               XRST_i,
  input  logic               CK_EE_i,
  input  logic               FRAME_i,
  input  logic               HOLD_i,
  input  logic               REQA_i,
  input  logic               REQB_i,
  input  logic [1:0]         OPA_i,
  input  logic [1:0]         OPB_i,
  input  logic [C_LED_N-1:0] DATA_A_i,
  input  logic [C_LED_N-1:0] DATA_B_i,
  output logic               ACKA_o,
  output logic               ACKB_o,
  output logic [C_LED_N-1:0] LEDs_ON_o,
  output logic               PEND_o,
  output logic               BLINK_PH_o
);

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_SET   = 2'd1;
  localparam logic [1:0] OP_CLR   = 2'd2;
  localparam logic [1:0] OP_BMASK = 2'd3;
  localparam logic [7:0] BCTR_MAX = 8'(C_BLINK_FRAMES - 1);

  logic [C_LED_N-1:0] shadow_q, shadow_d;
  logic [C_LED_N-1:0] bmask_q, bmask_d;
  logic [C_LED_N-1:0] csh_q, csh_d;
  logic [C_LED_N-1:0] cbm_q, cbm_d;
  logic [C_LED_N-1:0] leds_q, leds_d;
  logic [7:0]         bctr_q, bctr_d;
  logic               bph_q, bph_d;
  logic               last_rr_q, last_rr_d;
  logic               acka_q, acka_d;
  logic               ackb_q, ackb_d;
  logic               pend_q, pend_d;

  logic               elig_a, elig_b, gnt_a, gnt_b, commit;
  logic [1:0]         op_sel;
  logic [C_LED_N-1:0] data_sel;

  always_comb begin
    // A requester whose ACK is showing cannot be granted again this cycle.
    elig_a   = REQA_i & ~acka_q;
    elig_b   = REQB_i & ~ackb_q;
    gnt_a    = elig_a & (~elig_b | last_rr_q);
    gnt_b    = elig_b & (~elig_a | ~last_rr_q);
    op_sel   = gnt_b ? OPB_i : OPA_i;
    data_sel = gnt_b ? DATA_B_i : DATA_A_i;

    acka_d    = gnt_a;
    ackb_d    = gnt_b;
    shadow_d  = shadow_q;
    bmask_d   = bmask_q;
    last_rr_d = last_rr_q;
    if (gnt_a | gnt_b) begin
      last_rr_d = gnt_b;
      case (op_sel)
        OP_LOAD:  shadow_d = data_sel;
        OP_SET:   shadow_d = shadow_q | data_sel;
        OP_CLR:   shadow_d = shadow_q & ~data_sel;
        OP_BMASK: bmask_d  = data_sel;
        default:  shadow_d = shadow_q;
      endcase
    end

    bctr_d = bctr_q;
    bph_d  = bph_q;
    if (FRAME_i) begin
      if (bctr_q == BCTR_MAX) begin
        bctr_d = 8'd0;
        bph_d  = ~bph_q;
      end else begin
        bctr_d = bctr_q + 8'd1;
      end
    end

    // Commit samples the pre-edge shadow/mask but the post-pulse blink phase.
    commit = FRAME_i & ~HOLD_i;
    leds_d = leds_q;
    csh_d  = csh_q;
    cbm_d  = cbm_q;
    if (commit) begin
      leds_d = shadow_q ^ (bmask_q & {C_LED_N{bph_d}});
      csh_d  = shadow_q;
      cbm_d  = bmask_q;
    end

    pend_d = (shadow_d != csh_d) | (bmask_d != cbm_d);
  end

  always_ff @(posedge CK_i) begin
    if (!XRST_i) begin
      shadow_q  <= '0;
      bmask_q   <= '0;
      csh_q     <= '0;
      cbm_q     <= '0;
      leds_q    <= '0;
      bctr_q    <= 8'd0;
      bph_q     <= 1'b0;
      last_rr_q <= 1'b1;
      acka_q    <= 1'b0;
      ackb_q    <= 1'b0;
      pend_q    <= 1'b0;
    end else if (CK_EE_i) begin
      shadow_q  <= shadow_d;
      bmask_q   <= bmask_d;
      csh_q     <= csh_d;
      cbm_q     <= cbm_d;
      leds_q    <= leds_d;
      bctr_q    <= bctr_d;
      bph_q     <= bph_d;
      last_rr_q <= last_rr_d;
      acka_q    <= acka_d;
      ackb_q    <= ackb_d;
      pend_q    <= pend_d;
    end
  end

  assign ACKA_o     = acka_q;
  assign ACKB_o     = ackb_q;
  assign LEDs_ON_o  = leds_q;
  assign PEND_o     = pend_q;
  assign BLINK_PH_o = bph_q;

endmodule
